tag_readout_sched: RTL and testbench
====================================

// Module: tag_readout_sched
// PURPOSE
//  Round-robin scheduler that streams per-tag capture frames into the tag data
//  output buffer. Tags raise level requests when a capture frame is ready in the
//  shared capture RAM. The block grants one tag at a time and reads its
//  BURST_LEN words from RAM (1-cycle read latency). It emits them as one
//  AXI-stream packet: tuser = one-hot tag, tlast on the final word.
// PARAMETERS
//  NUM_TAGS    20   number of requesting tags
//  DATA_WIDTH  256  capture word / stream width
//  BURST_LEN   16   words per frame (power of two, >=2)
//  TW (local)  clog2(NUM_TAGS)   tag index width
//  BW (local)  clog2(BURST_LEN)  word index width
// PORTS
//  clk            in   1           clock
//  rst            in   1           asynchronous reset, active-high
//  en             in   1           1 = new grants allowed; 0 = finish current frame, then idle
//  req            in   NUM_TAGS    per-tag frame-ready request (level)
//  ack            out  NUM_TAGS    one-hot 1-cycle pulse: frame of that tag fully sent
//  ram_rd_en      out  1           capture RAM read strobe
//  ram_rd_addr    out  TW+BW       {tag_index, word_index}
//  ram_rd_data    in   DATA_WIDTH  RAM data, valid 1 cycle after ram_rd_en
//  m_axis_tvalid  out  1           stream valid
//  m_axis_tready  in   1           stream ready (from tag data buffer)
//  m_axis_tdata   out  DATA_WIDTH  frame word
//  m_axis_tuser   out  NUM_TAGS    one-hot granted tag, constant over the packet
//  m_axis_tlast   out  1           high on word BURST_LEN-1
//  busy           out  1           high from grant until ack
// BEHAVIOUR
//  - Reset (async): state IDLE, rr pointer = NUM_TAGS-1, all outputs 0, skid empty.
//  - FSM IDLE -> XFER: en=1 and req!=0. Grant = first set req bit scanning
//    upward from rr_ptr+1, modulo NUM_TAGS. Latch grant, rr_ptr<=grant index,
//    rd_cnt=0, tx_cnt=0. Arbitration takes 1 cycle; first ram_rd_en is no
//    earlier than the cycle after the grant.
//  - XFER: issue ram_rd_en while rd_cnt<BURST_LEN and (skid_occ + inflight) < 2.
//    ram_rd_addr = {grant_idx, rd_cnt}; rd_cnt++ on each read.
//  - Returning data enters a 2-entry skid FIFO. The FIFO head drives m_axis_*.
//    The beat transfers on tvalid & tready. tx_cnt++ per beat; tlast = (tx_cnt==BURST_LEN-1).
//  - Throughput: 1 beat/cycle with tready held high. tready low never drops or
//    duplicates a word. tdata/tuser/tlast are held stable while tvalid & ~tready.
//  - XFER -> DONE on the accepted tlast beat. DONE: ack[grant]=1 for one cycle,
//    busy=0, -> IDLE. A re-grant is possible at earliest 1 cycle after ack.
//  - req deasserting mid-frame is ignored; the frame completes.
//  - A req still high after its ack has lowest priority next round (RR).
//  - en=0 during XFER: the current frame completes; no new grant.
//  - req bits >= NUM_TAGS do not exist. Index arithmetic wraps modulo NUM_TAGS,
//    not 2^TW.
//  - rst mid-frame: the packet is abandoned. tvalid drops immediately, no ack,
//    rr pointer returns to reset value.
//  - m_axis_tuser is a registered one-hot copy of the grant. All outputs are registered.
// TESTING
//  1 Single req[3]=1, tready=1 -> 16 reads at addr 0x30..0x3F. 16 beats, tuser=0x00008,
//    tlast on beat 16. ack[3] pulses 1 cycle after the last beat. busy low after it.
//  2 req=0xFFFFF held, ack handshake drops each req -> grant order 0,1,2..19. Each
//    packet's tuser matches its ack bit.
//  3 req[5], tready toggling 1010.. then held low 10 cycles mid-packet -> 16 beats,
//    data in address order, no gaps or duplicates. tdata stable while stalled.
//  4 req[19] and req[0], rr_ptr=18 -> 19 granted first, then 0 (wrap at NUM_TAGS).
//  5 en=0 asserted at beat 4 of tag 7 -> frame completes, ack[7]. No further grant
//    with req[8]=1 until en=1.
//  6 rst pulsed at beat 8 -> tvalid, ram_rd_en, busy, ack all 0 asynchronously.
//    After release with req[2]=1, a fresh frame starts from word 0.

Source files
------------

// File: rtl/tag_readout_sched_if.sv
// Scheduler-facing bundle: tag request/ack, capture RAM read port, AXI-stream out.
// master = scheduler side, slave = tag/RAM/buffer side.
interface tag_readout_sched_if #(
  parameter int NUM_TAGS   = 20,
  parameter int DATA_WIDTH = 256,
  parameter int BURST_LEN  = 16
);
  localparam int TW = $clog2(NUM_TAGS);
  localparam int BW = $clog2(BURST_LEN);

  logic                  en;
  logic [NUM_TAGS-1:0]   req;
  logic [NUM_TAGS-1:0]   ack;
  logic                  busy;
  logic                  ram_rd_en;
  logic [TW+BW-1:0]      ram_rd_addr;
  logic [DATA_WIDTH-1:0] ram_rd_data;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic [NUM_TAGS-1:0]   m_axis_tuser;
  logic                  m_axis_tlast;

  modport master (
    input  en, req, ram_rd_data, m_axis_tready,
    output ack, busy, ram_rd_en, ram_rd_addr,
           m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast
  );

  modport slave (
    output en, req, ram_rd_data, m_axis_tready,
    input  ack, busy, ram_rd_en, ram_rd_addr,
           m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast
  );
endinterface

// File: rtl/tag_readout_sched.sv
// Round-robin tag scheduler: reads one BURST_LEN frame per grant from the capture
// RAM and streams it out as one AXI-stream packet.
//
//  state  | meaning
//  IDLE   | waiting for en & any req; arbitrates in one cycle
//  XFER   | reading frame words from RAM and streaming them out
//  DONE   | one-cycle ack pulse for the granted tag
module tag_readout_sched #(
  parameter int NUM_TAGS   = 20,
  parameter int DATA_WIDTH = 256,
  parameter int BURST_LEN  = 16
) (
  input  logic clk,
  input  logic rst,
  tag_readout_sched_if.master bus
);
  localparam int TW = $clog2(NUM_TAGS);
  localparam int BW = $clog2(BURST_LEN);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;

  state_t                state, state_nxt;
  logic [TW-1:0]         rr_ptr, grant_idx, arb_idx;
  logic                  arb_found;
  int                    cand;
  logic [NUM_TAGS-1:0]   arb_oh;
  logic [BW:0]           rd_cnt;
  logic [BW-1:0]         tx_cnt, ld_cnt;
  logic [1:0]            credit, credit_av;
  logic                  rd_pend;
  logic [DATA_WIDTH-1:0] skid_mem [2];
  logic                  skid_wp, skid_rp;
  logic [1:0]            skid_cnt;

  logic                  rd_en_q;
  logic [TW+BW-1:0]      rd_addr_q;
  logic                  tvalid_q, tlast_q, busy_q;
  logic [DATA_WIDTH-1:0] tdata_q;
  logic [NUM_TAGS-1:0]   tuser_q, ack_q;

  logic pop, out_free, sk_pop, sk_push, out_load, issue, grant_go, last_pop;

  assign bus.ram_rd_en     = rd_en_q;
  assign bus.ram_rd_addr   = rd_addr_q;
  assign bus.m_axis_tvalid = tvalid_q;
  assign bus.m_axis_tdata  = tdata_q;
  assign bus.m_axis_tuser  = tuser_q;
  assign bus.m_axis_tlast  = tlast_q;
  assign bus.ack           = ack_q;
  assign bus.busy          = busy_q;

  // Scan upward from rr_ptr+1, wrapping at NUM_TAGS rather than 2^TW.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = 0;
    for (int i = 1; i <= NUM_TAGS; i++) begin
      cand = int'(rr_ptr) + i;
      if (cand >= NUM_TAGS) cand = cand - NUM_TAGS;
      if (!arb_found && bus.req[cand[TW-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = cand[TW-1:0];
      end
    end
    arb_oh = NUM_TAGS'(1) << arb_idx;
  end

  // The output register plus two skid entries hold three words; credit counts
  // words issued to RAM but not yet accepted downstream, so it never exceeds 3.
  always_comb begin
    pop       = tvalid_q & bus.m_axis_tready;
    out_free  = ~tvalid_q | pop;
    sk_pop    = out_free & (skid_cnt != 2'd0);
    sk_push   = rd_pend & ~(out_free & (skid_cnt == 2'd0));
    out_load  = sk_pop | (out_free & rd_pend);
    last_pop  = pop & (tx_cnt == BW'(BURST_LEN - 1));
    credit_av = credit - {1'b0, pop};
    issue     = (state == S_XFER) && (rd_cnt < (BW+1)'(BURST_LEN)) && (credit_av != 2'd3);
    grant_go  = (state == S_IDLE) && bus.en && arb_found;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant_go) state_nxt = S_XFER;
      S_XFER:  if (last_pop) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sk_push) skid_mem[skid_wp] <= bus.ram_rd_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= TW'(NUM_TAGS - 1);
      grant_idx <= '0;
      rd_cnt    <= '0;
      tx_cnt    <= '0;
      ld_cnt    <= '0;
      credit    <= '0;
      rd_pend   <= 1'b0;
      skid_wp   <= 1'b0;
      skid_rp   <= 1'b0;
      skid_cnt  <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      tdata_q   <= '0;
      tuser_q   <= '0;
      ack_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      ack_q   <= '0;
      rd_pend <= rd_en_q;
      rd_en_q <= issue;
      credit  <= credit + {1'b0, issue} - {1'b0, pop};

      if (grant_go) begin
        grant_idx <= arb_idx;
        rr_ptr    <= arb_idx;
        tuser_q   <= arb_oh;
        rd_cnt    <= '0;
        tx_cnt    <= '0;
        ld_cnt    <= '0;
        busy_q    <= 1'b1;
      end

      if (issue) begin
        rd_addr_q <= {grant_idx, rd_cnt[BW-1:0]};
        rd_cnt    <= rd_cnt + 1'b1;
      end

      if (pop) tx_cnt <= tx_cnt + 1'b1;

      if (last_pop) begin
        ack_q   <= tuser_q;
        tuser_q <= '0;
        busy_q  <= 1'b0;
      end

      if (out_load) begin
        tdata_q  <= sk_pop ? skid_mem[skid_rp] : bus.ram_rd_data;
        tvalid_q <= 1'b1;
        tlast_q  <= (ld_cnt == BW'(BURST_LEN - 1));
        ld_cnt   <= ld_cnt + 1'b1;
      end else if (out_free) begin
        tvalid_q <= 1'b0;
        tlast_q  <= 1'b0;
      end

      if (sk_push) skid_wp <= ~skid_wp;
      if (sk_pop)  skid_rp <= ~skid_rp;
      skid_cnt <= skid_cnt + {1'b0, sk_push} - {1'b0, sk_pop};
    end
  end
endmodule

// File: tb/tb_tag_readout_sched.sv
// Directed bench for tag_readout_sched: RAM model returns an address-tagged word,
// a negedge monitor logs reads, beats and acks for the scenario tasks to check.
module tb_tag_readout_sched;
  localparam int NT = 20;
  localparam int DW = 256;
  localparam int BL = 16;
  localparam int AW = $clog2(NT) + $clog2(BL);

  logic clk, rst;
  int checks = 0;
  int errors = 0;
  bit auto_drop;

  tag_readout_sched_if #(.NUM_TAGS(NT), .DATA_WIDTH(DW), .BURST_LEN(BL)) bus ();

  tag_readout_sched #(.NUM_TAGS(NT), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW-1:0] mkdata(input logic [AW-1:0] a);
    logic [DW-1:0] d;
    for (int k = 0; k < 8; k++) d[k*32 +: 32] = {8'(k), 15'h1234, a};
    return d;
  endfunction

  always @(posedge clk) begin
    if (bus.ram_rd_en) bus.ram_rd_data <= mkdata(bus.ram_rd_addr);
  end

  int              cyc = 0;
  int              stall_cnt = 0;
  logic [AW-1:0]   rd_log[$];
  logic [DW-1:0]   b_data[$];
  logic [NT-1:0]   b_user[$];
  logic            b_last[$];
  int              b_cyc[$];
  logic [NT-1:0]   ack_log[$];
  int              ack_cyc[$];
  logic            ack_busy[$];
  logic            stall_prev = 1'b0;
  logic [DW-1:0]   stall_data;
  logic [NT-1:0]   stall_user;
  logic            stall_last;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== stall_data ||
            bus.m_axis_tuser !== stall_user || bus.m_axis_tlast !== stall_last) begin
          errors++;
          $display("FAIL stall_hold cyc=%0d got valid=%b user=%h last=%b word=%h expected valid=1 user=%h last=%b word=%h",
                   cyc, bus.m_axis_tvalid, bus.m_axis_tuser, bus.m_axis_tlast, bus.m_axis_tdata[31:0],
                   stall_user, stall_last, stall_data[31:0]);
        end
      end
      stall_prev = bus.m_axis_tvalid && !bus.m_axis_tready;
      if (stall_prev) stall_cnt++;
      stall_data = bus.m_axis_tdata;
      stall_user = bus.m_axis_tuser;
      stall_last = bus.m_axis_tlast;
      if (bus.ram_rd_en) rd_log.push_back(bus.ram_rd_addr);
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        b_data.push_back(bus.m_axis_tdata);
        b_user.push_back(bus.m_axis_tuser);
        b_last.push_back(bus.m_axis_tlast);
        b_cyc.push_back(cyc);
      end
      if (bus.ack != '0) begin
        ack_log.push_back(bus.ack);
        ack_cyc.push_back(cyc);
        ack_busy.push_back(bus.busy);
        if (auto_drop) bus.req = bus.req & ~bus.ack;
      end
    end
  end

  task automatic clear_logs();
    rd_log.delete(); b_data.delete(); b_user.delete(); b_last.delete(); b_cyc.delete();
    ack_log.delete(); ack_cyc.delete(); ack_busy.delete();
    stall_cnt = 0;
  endtask

  task automatic wait_acks(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (ack_log.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_beats(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (b_data.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.ram_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b expected 0", bus.ram_rd_en); end
    checks++; if (bus.m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b expected 0", bus.m_axis_tvalid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", bus.busy); end
    checks++; if (bus.ack !== '0) begin errors++; $display("FAIL reset_ack got %h expected 0", bus.ack); end
    checks++; if (bus.m_axis_tuser !== '0) begin errors++; $display("FAIL reset_tuser got %h expected 0", bus.m_axis_tuser); end
    checks++; if (bus.m_axis_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b expected 0", bus.m_axis_tlast); end
    rst = 1'b0;
    @(posedge clk); #1;
    clear_logs();
  endtask

  task automatic test_single();
    bit ok;
    bus.en = 1'b1; bus.m_axis_tready = 1'b1;
    bus.req = NT'(1) << 3;
    wait_acks(1, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout acks=%0d expected 1", ack_log.size()); end
    checks++; if (rd_log.size() != BL) begin errors++; $display("FAIL single_reads got %0d expected %0d", rd_log.size(), BL); end
    for (int i = 0; i < rd_log.size() && i < BL; i++) begin
      checks++; if (rd_log[i] !== AW'(48 + i)) begin errors++; $display("FAIL single_addr[%0d] got %h expected %h", i, rd_log[i], AW'(48 + i)); end
    end
    checks++; if (b_data.size() != BL) begin errors++; $display("FAIL single_beats got %0d expected %0d", b_data.size(), BL); end
    for (int i = 0; i < b_data.size() && i < BL; i++) begin
      checks++;
      if (b_data[i] !== mkdata(AW'(48 + i)) || b_user[i] !== NT'(20'h00008) ||
          b_last[i] !== (i == BL - 1) || b_cyc[i] !== b_cyc[0] + i) begin
        errors++;
        $display("FAIL single_beat[%0d] got word=%h user=%h last=%b cyc=%0d expected word=%h user=00008 last=%b cyc=%0d",
                 i, b_data[i][31:0], b_user[i], b_last[i], b_cyc[i], mkdata(AW'(48 + i)) & 256'hFFFFFFFF,
                 (i == BL - 1), b_cyc[0] + i);
      end
    end
    if (ack_log.size() >= 1 && b_cyc.size() == BL) begin
      checks++; if (ack_log[0] !== NT'(20'h00008)) begin errors++; $display("FAIL single_ack got %h expected 00008", ack_log[0]); end
      checks++; if (ack_cyc[0] !== b_cyc[BL-1] + 1) begin errors++; $display("FAIL single_ack_cycle got %0d expected %0d", ack_cyc[0], b_cyc[BL-1] + 1); end
      checks++; if (ack_busy[0] !== 1'b0) begin errors++; $display("FAIL single_busy_at_ack got %b expected 0", ack_busy[0]); end
    end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy_after got %b expected 0", bus.busy); end
    clear_logs();
  endtask

  task automatic test_all_tags();
    bit ok;
    pulse_reset();
    bus.req = {NT{1'b1}};
    wait_acks(NT, 900, ok);
    checks++; if (!ok) begin errors++; $display("FAIL all_timeout acks=%0d expected %0d", ack_log.size(), NT); end
    for (int i = 0; i < ack_log.size() && i < NT; i++) begin
      checks++; if (ack_log[i] !== NT'(1) << i) begin errors++; $display("FAIL all_ack[%0d] got %h expected %h", i, ack_log[i], NT'(1) << i); end
    end
    checks++; if (b_data.size() != NT * BL) begin errors++; $display("FAIL all_beats got %0d expected %0d", b_data.size(), NT * BL); end
    for (int i = 0; i < b_data.size() && i < NT * BL; i++) begin
      checks++;
      if (b_user[i] !== NT'(1) << (i / BL) || b_last[i] !== (i % BL == BL - 1) ||
          b_data[i] !== mkdata(AW'((i / BL) * BL + (i % BL)))) begin
        errors++;
        $display("FAIL all_beat[%0d] got user=%h last=%b word=%h expected user=%h last=%b",
                 i, b_user[i], b_last[i], b_data[i][31:0], NT'(1) << (i / BL), (i % BL == BL - 1));
      end
    end
    clear_logs();
  endtask

  task automatic test_stall();
    bit ok = 1'b0;
    int low_left = -1;
    bus.req = NT'(1) << 5;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      if (ack_log.size() >= 1) begin ok = 1'b1; break; end
      if (low_left < 0 && b_data.size() >= 4) low_left = 10;
      if (low_left > 0) begin bus.m_axis_tready = 1'b0; low_left--; end
      else if (low_left < 0) bus.m_axis_tready = ~bus.m_axis_tready;
      else bus.m_axis_tready = 1'b1;
    end
    bus.m_axis_tready = 1'b1;
    checks++; if (!ok) begin errors++; $display("FAIL stall_timeout acks=%0d expected 1", ack_log.size()); end
    checks++; if (stall_cnt < 10) begin errors++; $display("FAIL stall_cycles got %0d expected >=10", stall_cnt); end
    checks++; if (b_data.size() != BL) begin errors++; $display("FAIL stall_beats got %0d expected %0d", b_data.size(), BL); end
    for (int i = 0; i < b_data.size() && i < BL; i++) begin
      checks++;
      if (b_data[i] !== mkdata(AW'(80 + i)) || b_user[i] !== NT'(20'h00020) || b_last[i] !== (i == BL - 1)) begin
        errors++;
        $display("FAIL stall_beat[%0d] got word=%h user=%h last=%b expected addr=%h user=00020 last=%b",
                 i, b_data[i][31:0], b_user[i], b_last[i], AW'(80 + i), (i == BL - 1));
      end
    end
    if (ack_log.size() >= 1) begin
      checks++; if (ack_log[0] !== NT'(20'h00020)) begin errors++; $display("FAIL stall_ack got %h expected 00020", ack_log[0]); end
    end
    clear_logs();
  endtask

  task automatic test_wrap();
    bit ok;
    pulse_reset();
    bus.req = NT'(1) << 18;
    wait_acks(1, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_setup_timeout acks=%0d expected 1", ack_log.size()); end
    clear_logs();
    bus.req = (NT'(1) << 19) | NT'(1);
    wait_acks(2, 300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout acks=%0d expected 2", ack_log.size()); end
    if (ack_log.size() >= 2) begin
      checks++; if (ack_log[0] !== NT'(1) << 19) begin errors++; $display("FAIL wrap_first_ack got %h expected %h", ack_log[0], NT'(1) << 19); end
      checks++; if (ack_log[1] !== NT'(1)) begin errors++; $display("FAIL wrap_second_ack got %h expected %h", ack_log[1], NT'(1)); end
    end
    if (rd_log.size() >= 2 * BL && b_user.size() >= 2 * BL) begin
      checks++; if (rd_log[0] !== AW'(9'h130)) begin errors++; $display("FAIL wrap_first_addr got %h expected 130", rd_log[0]); end
      checks++; if (rd_log[BL] !== AW'(9'h000)) begin errors++; $display("FAIL wrap_second_addr got %h expected 000", rd_log[BL]); end
      checks++; if (b_user[BL] !== NT'(1)) begin errors++; $display("FAIL wrap_second_user got %h expected %h", b_user[BL], NT'(1)); end
    end else begin
      checks++; errors++; $display("FAIL wrap_counts reads=%0d beats=%0d expected %0d", rd_log.size(), b_user.size(), 2 * BL);
    end
    clear_logs();
  endtask

  task automatic test_enable();
    bit ok;
    bus.req = NT'(1) << 7;
    wait_beats(4, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL en_beat4_timeout beats=%0d expected 4", b_data.size()); end
    bus.en = 1'b0;
    bus.req = bus.req | (NT'(1) << 8);
    wait_acks(1, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL en_ack_timeout acks=%0d expected 1", ack_log.size()); end
    repeat (30) @(posedge clk);
    #1;
    checks++; if (ack_log.size() != 1) begin errors++; $display("FAIL en_ack_count got %0d expected 1", ack_log.size()); end
    if (ack_log.size() >= 1) begin
      checks++; if (ack_log[0] !== NT'(1) << 7) begin errors++; $display("FAIL en_ack7 got %h expected %h", ack_log[0], NT'(1) << 7); end
    end
    checks++; if (b_data.size() != BL) begin errors++; $display("FAIL en_beats got %0d expected %0d", b_data.size(), BL); end
    checks++; if (rd_log.size() != BL) begin errors++; $display("FAIL en_reads got %0d expected %0d", rd_log.size(), BL); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL en_idle_busy got %b expected 0", bus.busy); end
    bus.en = 1'b1;
    wait_acks(2, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL en_resume_timeout acks=%0d expected 2", ack_log.size()); end
    if (ack_log.size() >= 2 && rd_log.size() > BL) begin
      checks++; if (ack_log[1] !== NT'(1) << 8) begin errors++; $display("FAIL en_ack8 got %h expected %h", ack_log[1], NT'(1) << 8); end
      checks++; if (rd_log[BL] !== AW'(9'h080)) begin errors++; $display("FAIL en_tag8_addr got %h expected 080", rd_log[BL]); end
    end
    clear_logs();
  endtask

  task automatic test_mid_reset();
    bit ok;
    bus.req = NT'(1) << 2;
    wait_beats(8, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_beat8_timeout beats=%0d expected 8", b_data.size()); end
    rst = 1'b1;
    #1;
    checks++; if (bus.m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %b expected 0", bus.m_axis_tvalid); end
    checks++; if (bus.ram_rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en got %b expected 0", bus.ram_rd_en); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b expected 0", bus.busy); end
    checks++; if (bus.ack !== '0) begin errors++; $display("FAIL rst_ack got %h expected 0", bus.ack); end
    checks++; if (ack_log.size() != 0) begin errors++; $display("FAIL rst_no_ack got %0d acks expected 0", ack_log.size()); end
    @(posedge clk); #1;
    rst = 1'b0;
    clear_logs();
    wait_acks(1, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_refetch_timeout acks=%0d expected 1", ack_log.size()); end
    checks++; if (rd_log.size() != BL) begin errors++; $display("FAIL rst_reads got %0d expected %0d", rd_log.size(), BL); end
    if (rd_log.size() >= 1) begin
      checks++; if (rd_log[0] !== AW'(9'h020)) begin errors++; $display("FAIL rst_first_addr got %h expected 020", rd_log[0]); end
    end
    checks++; if (b_data.size() != BL) begin errors++; $display("FAIL rst_beats got %0d expected %0d", b_data.size(), BL); end
    for (int i = 0; i < b_data.size() && i < BL; i++) begin
      checks++; if (b_data[i] !== mkdata(AW'(32 + i))) begin errors++; $display("FAIL rst_beat[%0d] got word=%h expected addr=%h", i, b_data[i][31:0], AW'(32 + i)); end
    end
    if (ack_log.size() >= 1) begin
      checks++; if (ack_log[0] !== NT'(1) << 2) begin errors++; $display("FAIL rst_ack2 got %h expected %h", ack_log[0], NT'(1) << 2); end
    end
    clear_logs();
  endtask

  initial begin
    rst = 1'b0;
    auto_drop = 1'b1;
    bus.en = 1'b0;
    bus.req = '0;
    bus.m_axis_tready = 1'b1;
    #2 rst = 1'b1;
    test_reset();
    test_single();
    test_all_tags();
    test_stall();
    test_wrap();
    test_enable();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
